// File: rtl/plab3_mem_line_memory_responder_pkg.sv
// Shared memory-message definitions: field widths, type codes and the
// len-to-byte-count rule for the cacheline memory port.
package plab3_mem_line_memory_responder_pkg;

    localparam int TYPE_W     = 3;
    localparam int OPQ_W      = 8;
    localparam int LEN_W      = 4;
    localparam int LINE_BYTES = 16;

    localparam logic [TYPE_W-1:0] TYPE_READ       = 3'd0;
    localparam logic [TYPE_W-1:0] TYPE_WRITE      = 3'd1;
    localparam logic [TYPE_W-1:0] TYPE_WRITE_INIT = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic [4:0] len_to_nbytes(input logic [LEN_W-1:0] len);
        return (len == '0) ? 5'd16 : {1'b0, len};
    endfunction

    // Unknown type codes fall back to a read.
    function automatic logic is_write(input logic [TYPE_W-1:0] t);
        logic w;
        case (t)
            TYPE_WRITE, TYPE_WRITE_INIT: w = 1'b1;
            TYPE_READ:                   w = 1'b0;
            default:                     w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/plab3_mem_line_storage.sv
// Line array with per-byte write enables and a combinational read port.
// Contents are deliberately not reset.
module plab3_mem_line_storage #(
    parameter int nlines = 256,
    parameter int clw    = 128
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [$clog2(nlines)-1:0] i_idx,
    input  logic [clw/8-1:0]          i_be,
    input  logic [clw-1:0]            i_wdata,
    output logic [clw-1:0]            o_rdata
);

    logic [clw-1:0] r_mem [nlines];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < clw/8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/plab3_mem_line_memory_responder.sv
// Single-outstanding memory responder: byte-granular line access with a
// fixed, parameterised response latency.
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | counting down the extra latency
//   RESP  | response valid, held until accepted
module plab3_mem_line_memory_responder
    import plab3_mem_line_memory_responder_pkg::*;
#(
    parameter int nlines  = 256,
    parameter int latency = 0,
    parameter int abw     = 32,
    parameter int clw     = 128
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    input  logic                                      i_memreq_val,
    output logic                                      o_memreq_rdy,
    input  logic [TYPE_W+OPQ_W+abw+LEN_W+clw-1:0]     i_memreq_msg,
    output logic                                      o_memresp_val,
    input  logic                                      i_memresp_rdy,
    output logic [TYPE_W+OPQ_W+LEN_W+clw-1:0]         o_memresp_msg
);

    localparam int IW       = $clog2(nlines);
    localparam int LEN_LSB  = clw;
    localparam int ADDR_LSB = LEN_LSB + LEN_W;
    localparam int OPQ_LSB  = ADDR_LSB + abw;
    localparam int TYPE_LSB = OPQ_LSB + OPQ_W;
    localparam logic [3:0] LAT = 4'(latency);

    logic [TYPE_W-1:0] w_req_type;
    logic [OPQ_W-1:0]  w_req_opq;
    logic [abw-1:0]    w_req_addr;
    logic [LEN_W-1:0]  w_req_len;
    logic [clw-1:0]    w_req_data;
    logic [3:0]        w_off;
    logic [IW-1:0]     w_idx;
    logic [4:0]        w_nbytes;
    logic [LINE_BYTES-1:0] w_be;
    logic [clw-1:0]    w_bitmask;
    logic [clw-1:0]    w_line_rd;
    logic [clw-1:0]    w_wr_line;
    logic [clw-1:0]    w_rd_data;
    logic              w_accept;
    logic              w_is_wr;
    logic              w_unused_addr;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [TYPE_W-1:0] r_resp_type;
    logic [OPQ_W-1:0]  r_resp_opq;
    logic [LEN_W-1:0]  r_resp_len;
    logic [clw-1:0]    r_resp_data;

    assign w_req_type = i_memreq_msg[TYPE_LSB +: TYPE_W];
    assign w_req_opq  = i_memreq_msg[OPQ_LSB +: OPQ_W];
    assign w_req_addr = i_memreq_msg[ADDR_LSB +: abw];
    assign w_req_len  = i_memreq_msg[LEN_LSB +: LEN_W];
    assign w_req_data = i_memreq_msg[clw-1:0];

    // Upper address bits alias; only offset and index are decoded.
    assign w_off         = w_req_addr[3:0];
    assign w_idx         = w_req_addr[4 +: IW];
    assign w_unused_addr = ^w_req_addr[abw-1:4+IW];
    assign w_nbytes      = len_to_nbytes(w_req_len);
    assign w_is_wr       = is_write(w_req_type);
    assign w_accept      = i_memreq_val && o_memreq_rdy;

    // Bytes beyond the end of the line are dropped rather than wrapped.
    always_comb begin
        w_be      = '0;
        w_bitmask = '0;
        for (int j = 0; j < LINE_BYTES; j++) begin
            if ((5'(j) >= {1'b0, w_off}) &&
                (6'(j) < ({2'b00, w_off} + {1'b0, w_nbytes}))) begin
                w_be[j]              = 1'b1;
                w_bitmask[8*j +: 8]  = 8'hff;
            end
        end
    end

    assign w_wr_line = w_req_data << {w_off, 3'b000};
    assign w_rd_data = (w_line_rd & w_bitmask) >> {w_off, 3'b000};

    plab3_mem_line_storage #(
        .nlines (nlines),
        .clw    (clw)
    ) u_storage (
        .i_clk   (i_clk),
        .i_we    (w_accept && w_is_wr),
        .i_idx   (w_idx),
        .i_be    (w_be),
        .i_wdata (w_wr_line),
        .o_rdata (w_line_rd)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = (LAT == 4'd0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_cnt == 4'd1) w_state_nxt = ST_RESP;
            ST_RESP: if (o_memresp_val && i_memresp_rdy) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_memreq_rdy  = 1'b0;
        o_memresp_val = 1'b0;
        case (r_state)
            ST_IDLE: o_memreq_rdy  = i_reset;
            ST_RESP: o_memresp_val = i_reset;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= LAT;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_resp_type <= w_req_type;
            r_resp_opq  <= w_req_opq;
            r_resp_len  <= w_req_len;
            r_resp_data <= w_is_wr ? '0 : w_rd_data;
        end
    end

    assign o_memresp_msg = {r_resp_type, r_resp_opq, r_resp_len, r_resp_data};

endmodule
